weight_sum_accumulator: RTL and testbench

WEIGHT_SUM_ACCUMULATOR -- requirements
Module: weight_sum_accumulator

---
 rtl/weight_sum_accumulator.sv | 193 +++++++++++++++++++
 tb/tb_weight_sum_accumulator.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_sum_accumulator.sv
// -----------------------------------------------------------------------------
// weight_sum_accumulator
//
// Collects weighted spike events into per-neuron excitatory/inhibitory sum
// slots for one timestep, then drains every slot (index 0..NEURON_COUNT-1)
// to the neuron unit over a valid/ready handshake. Each drained slot is
// cleared as it is accepted, so the block is ready for the next timestep.
//
// FSM: IDLE -> (TimestepStart) -> ACCUM -> (TimestepEnd) -> DRAIN -> IDLE
//
// Ports
//   Clock, Reset                 clock, async active-low reset
//   TimestepStart/TimestepEnd    one-cycle pulses that open/close accumulation
//   SpikeValid/SpikeReady        spike handshake (ready only in ACCUM)
//   SpikeNeuronID/SpikeWeight    target slot and signed fixed-point weight
//   SpikeInhibitory              0 = excitatory sum, 1 = inhibitory sum
//   SumValid/SumReady            drain handshake (valid only in DRAIN)
//   SumNeuronID/ExWeightSum/InWeightSum  offered slot, zero outside DRAIN
//   Busy                         state != IDLE
//   Overflow                     sticky signed overflow, cleared by reset or
//                                by TimestepStart accepted in IDLE
//
// Build option
//   WTSUM_SATURATE_EN  defined: overflowing sums clamp to max/min value;
//                      undefined: two's-complement wrap. Overflow sets in both.
// -----------------------------------------------------------------------------

// One neuron's excitatory/inhibitory sum pair with its own adder.
module weight_sum_slot #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  add_en,
   input  logic                  add_inhib,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] weight,
   output logic [DATA_WIDTH-1:0] ex_sum,
   output logic [DATA_WIDTH-1:0] in_sum,
   output logic                  ovf
);
   localparam int MSB = DATA_WIDTH - 1;
`ifdef WTSUM_SATURATE_EN
   localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

   logic [DATA_WIDTH-1:0] addend;
   logic [DATA_WIDTH-1:0] raw;
   logic [DATA_WIDTH-1:0] result;

   always_comb begin
      addend = add_inhib ? in_sum : ex_sum;
      raw    = addend + weight;
      // Same-sign operands producing an opposite-sign result is the only
      // way a signed add can leave the representable range.
      ovf    = add_en && (addend[MSB] == weight[MSB]) && (raw[MSB] != addend[MSB]);
      result = raw;
`ifdef WTSUM_SATURATE_EN
      if (ovf) result = addend[MSB] ? MIN_NEG : MAX_POS;
`endif
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ex_sum <= '0;
         in_sum <= '0;
      end else if (clr) begin
         ex_sum <= '0;
         in_sum <= '0;
      end else if (add_en) begin
         if (add_inhib) in_sum <= result;
         else           ex_sum <= result;
      end
   end
endmodule

module weight_sum_accumulator #(
   parameter int INTEGER_WIDTH   = 32,
   parameter int DATA_WIDTH_FRAC = 32,
   parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
   parameter int NEURON_COUNT    = 8,
   parameter int NID_WIDTH       = 3
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  TimestepStart,
   input  logic                  TimestepEnd,
   input  logic                  SpikeValid,
   output logic                  SpikeReady,
   input  logic [NID_WIDTH-1:0]  SpikeNeuronID,
   input  logic [DATA_WIDTH-1:0] SpikeWeight,
   input  logic                  SpikeInhibitory,
   output logic                  SumValid,
   input  logic                  SumReady,
   output logic [NID_WIDTH-1:0]  SumNeuronID,
   output logic [DATA_WIDTH-1:0] ExWeightSum,
   output logic [DATA_WIDTH-1:0] InWeightSum,
   output logic                  Busy,
   output logic                  Overflow
);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t                                  state, state_nxt;
   logic [NID_WIDTH-1:0]                    index;
   logic                                    spike_hs;
   logic                                    drain_hs;
   logic                                    last_idx;
   logic [NEURON_COUNT-1:0][DATA_WIDTH-1:0] ex_all;
   logic [NEURON_COUNT-1:0][DATA_WIDTH-1:0] in_all;
   logic [NEURON_COUNT-1:0]                 ovf_all;
   logic [NEURON_COUNT-1:0]                 add_en;
   logic [NEURON_COUNT-1:0]                 clr;

   always_comb begin
      spike_hs = (state == ACCUM) && SpikeValid;
      drain_hs = (state == DRAIN) && SumReady;
      last_idx = (index == NID_WIDTH'(NEURON_COUNT - 1));
   end

   // Slot array. An out-of-range SpikeNeuronID matches no slot, so the
   // spike is still handshaken but leaves every sum untouched.
   for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_slot
      assign add_en[g] = spike_hs && (SpikeNeuronID == NID_WIDTH'(g));
      assign clr[g]    = drain_hs && (index == NID_WIDTH'(g));

      weight_sum_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .Clock     (Clock),
         .Reset     (Reset),
         .add_en    (add_en[g]),
         .add_inhib (SpikeInhibitory),
         .clr       (clr[g]),
         .weight    (SpikeWeight),
         .ex_sum    (ex_all[g]),
         .in_sum    (in_all[g]),
         .ovf       (ovf_all[g])
      );
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      SpikeReady = 1'b0;
      SumValid   = 1'b0;
      Busy       = 1'b1;
      unique case (state)
         IDLE: begin
            Busy = 1'b0;
            if (TimestepStart) state_nxt = ACCUM;
         end
         ACCUM: begin
            SpikeReady = 1'b1;
            if (TimestepEnd) state_nxt = DRAIN;
         end
         DRAIN: begin
            SumValid = 1'b1;
            if (SumReady && last_idx) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Drain index sits at 0 outside DRAIN so every drain starts at slot 0.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)                     index <= '0;
      else if (state != DRAIN)        index <= '0;
      else if (drain_hs && last_idx)  index <= '0;
      else if (drain_hs)              index <= index + 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)                               Overflow <= 1'b0;
      else if ((state == IDLE) && TimestepStart) Overflow <= 1'b0;
      else if (|ovf_all)                        Overflow <= 1'b1;
   end

   // Slot contents only change on the accepting edge, so the offered pair
   // stays stable while SumReady is low.
   always_comb begin
      SumNeuronID = '0;
      ExWeightSum = '0;
      InWeightSum = '0;
      if (state == DRAIN) begin
         SumNeuronID = index;
         ExWeightSum = ex_all[index];
         InWeightSum = in_all[index];
      end
   end
endmodule

// File: tb/tb_weight_sum_accumulator.sv
module tb_weight_sum_accumulator;
   localparam int NC = 8;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        TimestepStart, TimestepEnd, SpikeValid, SpikeInhibitory, SumReady;
   logic [2:0]  SpikeNeuronID;
   logic [63:0] SpikeWeight;
   logic        SpikeReady, SumValid, Busy, Overflow;
   logic [2:0]  SumNeuronID;
   logic [63:0] ExWeightSum, InWeightSum;

   // second instance with NEURON_COUNT=6 for out-of-range id handling
   logic        b_start, b_end, b_sv, b_inh, b_sr;
   logic [2:0]  b_id;
   logic [63:0] b_w;
   logic        b_SpikeReady, b_SumValid, b_Busy, b_Overflow;
   logic [2:0]  b_SumNeuronID;
   logic [63:0] b_Ex, b_In;

   always #5 Clock = ~Clock;

   weight_sum_accumulator dut (
      .Clock(Clock), .Reset(Reset), .TimestepStart(TimestepStart), .TimestepEnd(TimestepEnd),
      .SpikeValid(SpikeValid), .SpikeReady(SpikeReady), .SpikeNeuronID(SpikeNeuronID),
      .SpikeWeight(SpikeWeight), .SpikeInhibitory(SpikeInhibitory), .SumValid(SumValid),
      .SumReady(SumReady), .SumNeuronID(SumNeuronID), .ExWeightSum(ExWeightSum),
      .InWeightSum(InWeightSum), .Busy(Busy), .Overflow(Overflow));

   weight_sum_accumulator #(.NEURON_COUNT(6)) dut6 (
      .Clock(Clock), .Reset(Reset), .TimestepStart(b_start), .TimestepEnd(b_end),
      .SpikeValid(b_sv), .SpikeReady(b_SpikeReady), .SpikeNeuronID(b_id),
      .SpikeWeight(b_w), .SpikeInhibitory(b_inh), .SumValid(b_SumValid),
      .SumReady(b_sr), .SumNeuronID(b_SumNeuronID), .ExWeightSum(b_Ex),
      .InWeightSum(b_In), .Busy(b_Busy), .Overflow(b_Overflow));

   typedef struct {
      logic [2:0]  id;
      logic [63:0] ex;
      logic [63:0] inh;
   } exp_t;

   exp_t        sq[$];
   logic [63:0] mex[NC];
   logic [63:0] minh[NC];
   bit          movf;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference add: exact sum in 65 bits, out of 64-bit signed range = overflow.
   function automatic logic [63:0] madd(input logic [63:0] a, input logic [63:0] b, output bit o);
      logic signed [64:0] w;
      w = $signed({a[63], a}) + $signed({b[63], b});
      o = (w > $signed(65'h0_7FFF_FFFF_FFFF_FFFF)) || (w < $signed(65'h1_8000_0000_0000_0000));
`ifdef WTSUM_SATURATE_EN
      if (o) return w[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return w[63:0];
   endfunction

   function automatic logic [63:0] rand_w();
      logic [31:0] s;
      s = $urandom;
      if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
      return {{32{s[31]}}, s};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NC; i++) begin
         mex[i]  = '0;
         minh[i] = '0;
      end
   endtask

   task automatic model_add(input logic [2:0] id, input logic [63:0] w, input bit inh);
      bit o;
      if (int'(id) < NC) begin
         if (inh) minh[id] = madd(minh[id], w, o);
         else     mex[id]  = madd(mex[id], w, o);
         if (o) movf = 1'b1;
      end
   endtask

   // Scoreboard monitor: the head entry must be on the outputs whenever
   // SumValid is high; it is retired on the handshake.
   always @(negedge Clock) begin
      if (Reset) begin
         if (SumValid) begin
            if (sq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_sum actual=valid_id%0d required=no_valid", SumNeuronID);
            end else begin
               chk("sum_id", 64'(SumNeuronID), 64'(sq[0].id));
               chk("ex_sum", ExWeightSum, sq[0].ex);
               chk("in_sum", InWeightSum, sq[0].inh);
               if (SumReady) void'(sq.pop_front());
            end
         end else begin
            chk("outputs_zero_outside_drain", ExWeightSum | InWeightSum | 64'(SumNeuronID), 64'd0);
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic ts_start();
      chk("busy_idle", Busy, 0);
      chk("spike_ready_idle", SpikeReady, 0);
      TimestepStart = 1'b1;
      tick();
      TimestepStart = 1'b0;
      movf = 1'b0;
      chk("busy_accum", Busy, 1);
      chk("overflow_cleared_by_start", Overflow, 0);
   endtask

   task automatic spike(input logic [2:0] id, input logic [63:0] w, input bit inh);
      SpikeValid      = 1'b1;
      SpikeNeuronID   = id;
      SpikeWeight     = w;
      SpikeInhibitory = inh;
      chk("spike_ready_accum", SpikeReady, 1);
      tick();
      SpikeValid = 1'b0;
      model_add(id, w, inh);
   endtask

   task automatic ts_end(input bit ws, input logic [2:0] id, input logic [63:0] w, input bit inh);
      exp_t e;
      TimestepEnd = 1'b1;
      if (ws) begin
         SpikeValid      = 1'b1;
         SpikeNeuronID   = id;
         SpikeWeight     = w;
         SpikeInhibitory = inh;
      end
      tick();
      TimestepEnd = 1'b0;
      SpikeValid  = 1'b0;
      if (ws) model_add(id, w, inh);
      for (int i = 0; i < NC; i++) begin
         e.id  = 3'(i);
         e.ex  = mex[i];
         e.inh = minh[i];
         sq.push_back(e);
      end
      model_clear();
      chk("drain_first_valid", SumValid, 1);
   endtask

   // mode 0: ready always, 1: ready low for 4 cycles at index 0, 2: random
   task automatic drain(input int mode);
      int n = 0;
      while (sq.size() > 0 && n < 300) begin
         case (mode)
            0:       SumReady = 1'b1;
            1:       SumReady = (n >= 4);
            default: SumReady = 1'($urandom_range(0, 1));
         endcase
         if (mode == 1 && n < 4) chk("hold_valid", SumValid, 1);
         tick();
         n++;
      end
      SumReady = 1'b0;
      if (sq.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d_left required=0", sq.size());
         sq.delete();
      end
      chk("busy_after_drain", Busy, 0);
      chk("overflow_flag", Overflow, movf);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      Reset = 1'b0;
      {TimestepStart, TimestepEnd, SpikeValid, SpikeInhibitory, SumReady} = '0;
      SpikeNeuronID = '0;
      SpikeWeight   = '0;
      {b_start, b_end, b_sv, b_inh, b_sr} = '0;
      b_id = '0;
      b_w  = '0;
      movf = 1'b0;
      model_clear();
      tick();
      tick();
      chk("rst_busy", Busy, 0);
      chk("rst_sum_valid", SumValid, 0);
      chk("rst_spike_ready", SpikeReady, 0);
      chk("rst_overflow", Overflow, 0);
      chk("rst_ex", ExWeightSum, 0);
      chk("rst_in", InWeightSum, 0);
      Reset = 1'b1;

      // basic accumulation, Start taken on the first edge after release
      ts_start();
      spike(3'd2, 64'h1_8000_0000, 1'b0);
      spike(3'd2, 64'h2_4000_0000, 1'b0);
      spike(3'd2, 64'h0_8000_0000, 1'b1);
      ts_end(1'b0, 3'd0, 64'd0, 1'b0);
      drain(0);

      // backpressure at index 0
      ts_start();
      spike(3'd0, 64'h5_0000_0000, 1'b0);
      spike(3'd0, 64'hFFFF_FFFF_0000_0000, 1'b1);
      spike(3'd7, 64'h0_0000_0001, 1'b1);
      ts_end(1'b0, 3'd0, 64'd0, 1'b0);
      drain(1);

      // signed overflow on slot 0
      ts_start();
      spike(3'd0, 64'h7FFF_FFFF_0000_0000, 1'b0);
      spike(3'd0, 64'h7FFF_FFFF_0000_0000, 1'b0);
      ts_end(1'b0, 3'd0, 64'd0, 1'b0);
      drain(0);
      chk("overflow_sticky", Overflow, 1);

      // spike offered in IDLE is refused; spike in the End cycle counts
      SpikeValid      = 1'b1;
      SpikeNeuronID   = 3'd1;
      SpikeWeight     = 64'h1_0000_0000;
      SpikeInhibitory = 1'b0;
      chk("spike_ready_idle_offer", SpikeReady, 0);
      tick();
      SpikeValid = 1'b0;
      ts_start();
      ts_end(1'b1, 3'd1, 64'h1_0000_0000, 1'b0);
      drain(0);

      // reset in the middle of ACCUM
      ts_start();
      spike(3'd4, 64'h3_0000_0000, 1'b0);
      spike(3'd5, 64'h1_0000_0000, 1'b1);
      spike(3'd4, 64'h7FFF_FFFF_0000_0000, 1'b0);
      Reset = 1'b0;
      #1;
      chk("midreset_busy", Busy, 0);
      chk("midreset_spike_ready", SpikeReady, 0);
      chk("midreset_sum_valid", SumValid, 0);
      chk("midreset_outputs", ExWeightSum | InWeightSum, 0);
      model_clear();
      movf = 1'b0;
      tick();
      Reset = 1'b1;
      ts_start();
      ts_end(1'b0, 3'd0, 64'd0, 1'b0);
      drain(0);

      // NEURON_COUNT=6: id 7 accepted and discarded
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_sv = 1'b1;
      b_id = 3'd7;
      b_w  = 64'h1_0000_0000;
      chk("nc6_ready_out_of_range", b_SpikeReady, 1);
      tick();
      b_id = 3'd3;
      b_w  = 64'h2_0000_0000;
      tick();
      b_sv  = 1'b0;
      b_end = 1'b1;
      tick();
      b_end = 1'b0;
      b_sr  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("nc6_valid", b_SumValid, 1);
         chk("nc6_id", 64'(b_SumNeuronID), 64'(k));
         chk("nc6_ex", b_Ex, (k == 3) ? 64'h2_0000_0000 : 64'd0);
         chk("nc6_in", b_In, 64'd0);
         tick();
      end
      b_sr = 1'b0;
      chk("nc6_busy_after_drain", b_Busy, 0);

      // randomized timesteps
      for (int t = 0; t < 10; t++) begin
         int n;
         ts_start();
         n = $urandom_range(1, 14);
         for (int s = 0; s < n; s++) begin
            if ($urandom_range(0, 3) == 0) begin
               TimestepStart = 1'($urandom_range(0, 1));
               tick();
               TimestepStart = 1'b0;
            end
            spike(3'($urandom_range(0, 7)), rand_w(), bit'($urandom_range(0, 1)));
         end
         ts_end(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_w(),
                bit'($urandom_range(0, 1)));
         drain($urandom_range(0, 2));
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
